// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_BAUD   = 4'h8;

  // STATUS bit positions
  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Store funct3 encodings
  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Only SB/SH/SW are real stores; other codes must not touch registers
  function automatic logic is_store_type(input logic [2:0] t);
    return (t == ST_SB) || (t == ST_SH) || (t == ST_SW);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed: contents are only visible through count
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory on the store port.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_en,
  input  logic [2:0]  s_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [3:0]  offset;
  logic        wr_en, push_req, clr_ovf, baud_wr;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic [31:0] status;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:16];

  assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = mem_addr[3:0];
  assign wr_en    = mem_write_en && hit && is_store_type(s_type);
  assign push_req = wr_en && (offset == OFS_TXDATA);
  assign clr_ovf  = wr_en && (offset == OFS_STATUS);
  assign baud_wr  = wr_en && (offset == OFS_BAUD) && (s_type != ST_SB);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_req),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Config/status next state; a zero divisor would stall the bit counter, so store 1
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (baud_wr) div_d = (mem_wdata[15:0] == 16'd0) ? 16'd1 : mem_wdata[15:0];
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Config/status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // STATUS word assembly
  always_comb begin
    status                        = '0;
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_BUSY]             = (state_q != IDLE);
    status[STAT_OVF]              = ovf_q;
    status[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
  end

  // Combinational read mux; reads never alter state
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        OFS_STATUS: rdata = status;
        OFS_BAUD:   rdata = {16'b0, div_q};
        default:    rdata = '0;
      endcase
    end
  end

  // Transmit FSM next state: each bit lasts bit_div clocks via a down-counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_div_d = bit_div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_div_d = div_q;
          cnt_d     = div_q - 16'd1;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = bit_div_q - 16'd1;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = bit_div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  // Transmit FSM registers; tx is registered so the pin is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_div_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_div_q <= bit_div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model feeds a scoreboard; a monitor
// decodes the tx pin and checks each frame against the expected byte and bit timing.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          DDIV  = 868;

  logic        clk = 1'b0;
  logic        reset, mem_write_en, hit, tx;
  logic [2:0]  s_type;
  logic [31:0] mem_addr, mem_wdata, rdata;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'(DDIV))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_en (mem_write_en),
    .s_type       (s_type),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .hit          (hit),
    .rdata        (rdata),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
    int         div;
  } frame_t;

  int         checks = 0;
  int         errors = 0;
  frame_t     exp_q[$];
  logic [7:0] pend[$];
  int         cyc = 0;
  int         m_div = DDIV;
  int         next_free = 0;
  int         busy_end = 0;
  bit         m_ovf = 1'b0;
  bit         rst_last = 1'b0;
  bit         mon_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: a byte starts its frame on the first edge after it was stored at which
  // the line is free; a frame uses the divisor in force at its start and occupies 10*div
  // clocks, followed by one idle clock before the next start.
  initial begin : model
    frame_t f;
    forever begin
      @(posedge clk);
      cyc++;
      rst_last = reset;
      if (reset) begin
        pend.delete();
        exp_q.delete();
        m_div     = DDIV;
        m_ovf     = 1'b0;
        next_free = 0;
        busy_end  = 0;
      end else begin
        if (pend.size() > 0 && cyc >= next_free) begin
          f.data    = pend.pop_front();
          f.start   = cyc;
          f.div     = m_div;
          exp_q.push_back(f);
          next_free = cyc + 10 * m_div + 1;
          busy_end  = cyc + 10 * m_div;
        end
        if (mem_write_en && mem_addr[31:4] == BASE[31:4] &&
            (s_type == ST_SB || s_type == ST_SH || s_type == ST_SW)) begin
          case (mem_addr[3:0])
            4'h0: if (pend.size() < DEPTH) pend.push_back(mem_wdata[7:0]); else m_ovf = 1'b1;
            4'h4: m_ovf = 1'b0;
            4'h8: if (s_type != ST_SB) m_div = (mem_wdata[15:0] == 16'd0) ? 1 : int'(mem_wdata[15:0]);
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] v;
    v       = '0;
    v[0]    = (pend.size() == DEPTH);
    v[1]    = (pend.size() == 0);
    v[2]    = (cyc < busy_end);
    v[3]    = m_ovf;
    v[15:8] = 8'(pend.size());
    return v;
  endfunction

  // Monitor: a falling tx while idle is a frame start; pop the scoreboard and check every clock
  initial begin : monitor
    frame_t     cur;
    int         k;
    logic [9:0] pat;
    forever begin
      @(negedge clk);
      if (mon_active && rst_last) mon_active = 1'b0;
      if (!mon_active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("spurious start bit", 32'(tx), 32'd1);
        end else begin
          cur = exp_q.pop_front();
          chk("frame start cycle", cyc, cur.start);
          cur.start  = cyc;
          mon_active = 1'b1;
        end
      end else if (!mon_active && exp_q.size() > 0 && exp_q[0].start < cyc) begin
        chk("frame start missing", 32'(tx), 32'd0);
        void'(exp_q.pop_front());
      end
      if (mon_active) begin
        k   = cyc - cur.start;
        pat = {1'b1, cur.data, 1'b0};
        chk($sformatf("frame %h bit %0d", cur.data, k / cur.div), 32'(tx),
            32'(pat[k / cur.div]));
        if (k == 10 * cur.div - 1) mon_active = 1'b0;
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    mem_addr     = a;
    s_type       = t;
    mem_wdata    = d;
    mem_write_en = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    mem_addr = a;
    s_type   = ST_SW;
    #1;
    chk(name, rdata, e);
    chk({name, " hit"}, 32'(hit), 32'(a[31:4] == BASE[31:4]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend.size() > 0 || cyc < next_free) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain within budget", 32'(n < 5000), 32'd1);
    idle(2);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int unsigned r;
    reset        = 1'b1;
    mem_write_en = 1'b0;
    s_type       = ST_SW;
    mem_addr     = '0;
    mem_wdata    = '0;
    idle(3);
    reset = 1'b0;

    chk("reset tx", 32'(tx), 32'd1);
    rd("reset status", BASE + 4, 32'h2);
    rd("reset baud", BASE + 8, 32'd868);

    // Single 0xA5 frame at div 4
    store(BASE + 8, ST_SW, 32'd4);
    rd("baud 4", BASE + 8, 32'd4);
    store(BASE, ST_SB, 32'hFFFF_FFA5);
    idle(2);
    rd("status busy", BASE + 4, 32'h6);
    idle(45);
    rd("status after frame", BASE + 4, 32'h2);

    // Fill past depth: nine accepted, tenth overflows
    for (int i = 1; i <= 10; i++) store(BASE, (i % 2 == 1) ? ST_SW : ST_SB, 32'(i));
    rd("status overflow", BASE + 4, 32'h80D);
    store(BASE + 4, ST_SW, 32'h0);
    rd("status ovf cleared", BASE + 4, 32'h805);
    wait_idle();

    // Divisor change mid-frame applies from the next frame
    store(BASE, ST_SB, 32'h3C);
    store(BASE, ST_SB, 32'h81);
    idle(10);
    store(BASE + 8, ST_SW, 32'd8);
    rd("baud 8", BASE + 8, 32'd8);
    wait_idle();

    // Zero divisor stored as 1
    store(BASE + 8, ST_SH, 32'hABCD_0000);
    rd("baud zero -> 1", BASE + 8, 32'd1);
    store(BASE, ST_SW, 32'h55);
    wait_idle();

    // Reset during data bit 3
    store(BASE + 8, ST_SW, 32'd4);
    store(BASE, ST_SB, 32'hC3);
    idle(18);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("tx after mid-frame reset", 32'(tx), 32'd1);
    rd("status after reset", BASE + 4, 32'h2);
    rd("baud after reset", BASE + 8, 32'd868);

    // Misses and ignored stores
    store(BASE + 32'h10, ST_SW, 32'h77);
    rd("read above window", BASE + 32'h10, 32'h0);
    store(32'h0FFF_FFFC, ST_SW, 32'h78);
    rd("read below window", 32'h0FFF_FFFC, 32'h0);
    store(BASE, 3'b111, 32'h79);
    store(BASE + 32'hC, ST_SW, 32'h7A);
    rd("read offset C", BASE + 32'hC, 32'h0);
    rd("status after misses", BASE + 4, 32'h2);
    store(BASE + 8, ST_SB, 32'h0000_0005);
    rd("baud after SB", BASE + 8, 32'd868);
    rd("txdata reads zero", BASE, 32'h0);
    idle(5);

    // Randomised traffic
    store(BASE + 8, ST_SW, 32'd2);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        store(BASE, 3'($urandom_range(0, 2)), $urandom);
      end else if (r == 5) begin
        store(BASE + 8, 3'($urandom_range(0, 2)),
              {16'($urandom), 16'($urandom_range(0, 4))});
      end else if (r == 6) begin
        store(BASE + 4, ST_SW, $urandom);
      end else if (r == 7) begin
        rd("random status", BASE + 4, exp_status());
      end else if (r == 8) begin
        rd("random baud", BASE + 8, 32'(m_div));
      end else begin
        idle($urandom_range(1, 12));
      end
    end
    wait_idle();
    rd("final status", BASE + 4, exp_status());
    chk("scoreboard drained", 32'(exp_q.size()) + 32'(mon_active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
